// File: rtl/echo_filter.sv
// Echo pulse-width conditioner: range-checks raw widths, averages accepted readings
// over a power-of-2 window and flags target loss after repeated rejects.
module echo_filter #(
   parameter logic [31:0] MIN_CYCLES   = 32'd1400,
   parameter logic [31:0] MAX_CYCLES   = 32'd280000,
   parameter int          LOG2_DEPTH   = 2,
   parameter int          REJECT_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [31:0] sample_cycles,
   output logic [31:0] filt_cycles,
   output logic        filt_valid,
   output logic        no_target,
   output logic [7:0]  reject_cnt
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int PTR_W = LOG2_DEPTH;
   localparam int SUM_W = 32 + LOG2_DEPTH;

   typedef enum logic {ST_EMPTY, ST_RUN} state_t;

   // Stage 1: capture and range check
   logic        s1_valid_reg;
   logic [31:0] s1_data_reg;
   logic        s1_in_range_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg    <= 1'b0;
         s1_data_reg     <= '0;
         s1_in_range_reg <= 1'b0;
      end else begin
         s1_valid_reg    <= sample_valid;
         s1_data_reg     <= sample_cycles;
         s1_in_range_reg <= (sample_cycles >= MIN_CYCLES) && (sample_cycles <= MAX_CYCLES);
      end
   end

   // Stage 2 state
   state_t             state_reg, state_next;
   logic [SUM_W-1:0]   sum_reg, sum_next;
   logic [PTR_W-1:0]   ptr_reg, ptr_next;
   logic [31:0]        filt_reg, filt_next;
   logic               filt_valid_reg, filt_valid_next;
   logic               no_target_reg, no_target_next;
   logic [7:0]         reject_cnt_reg, reject_cnt_next;
   logic [31:0]        buf_mem [DEPTH];
   logic [DEPTH-1:0]   buf_we;
   logic               prime_all;
   logic               run_wr;
   logic [31:0]        buf_rd;
   logic [7:0]         reject_inc;
   logic               limit_hit;

   assign buf_rd     = buf_mem[ptr_reg];
   assign reject_inc = (reject_cnt_reg == 8'hFF) ? 8'hFF : reject_cnt_reg + 8'd1;
   assign limit_hit  = int'({24'd0, reject_inc}) >= REJECT_LIMIT;

   // Priming fills every slot so the first average equals the first sample
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_we
         assign buf_we[gi] = prime_all || (run_wr && (ptr_reg == PTR_W'(gi)));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (buf_we[i]) buf_mem[i] <= s1_data_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_EMPTY;
         sum_reg        <= '0;
         ptr_reg        <= '0;
         filt_reg       <= '0;
         filt_valid_reg <= 1'b0;
         no_target_reg  <= 1'b1;
         reject_cnt_reg <= '0;
      end else begin
         state_reg      <= state_next;
         sum_reg        <= sum_next;
         ptr_reg        <= ptr_next;
         filt_reg       <= filt_next;
         filt_valid_reg <= filt_valid_next;
         no_target_reg  <= no_target_next;
         reject_cnt_reg <= reject_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      sum_next        = sum_reg;
      ptr_next        = ptr_reg;
      filt_next       = filt_reg;
      filt_valid_next = 1'b0;
      no_target_next  = no_target_reg;
      reject_cnt_next = reject_cnt_reg;
      prime_all       = 1'b0;
      run_wr          = 1'b0;

      if (s1_valid_reg) begin
         case (state_reg)
            ST_EMPTY: begin
               if (s1_in_range_reg) begin
                  prime_all       = 1'b1;
                  sum_next        = {s1_data_reg, {LOG2_DEPTH{1'b0}}};
                  ptr_next        = PTR_W'(1);
                  filt_next       = s1_data_reg;
                  filt_valid_next = 1'b1;
                  no_target_next  = 1'b0;
                  reject_cnt_next = '0;
                  state_next      = ST_RUN;
               end else begin
                  reject_cnt_next = reject_inc;
               end
            end
            ST_RUN: begin
               if (s1_in_range_reg) begin
                  run_wr          = 1'b1;
                  sum_next        = sum_reg - {{LOG2_DEPTH{1'b0}}, buf_rd}
                                            + {{LOG2_DEPTH{1'b0}}, s1_data_reg};
                  ptr_next        = ptr_reg + PTR_W'(1);
                  filt_next       = sum_next[SUM_W-1:LOG2_DEPTH];
                  filt_valid_next = 1'b1;
                  reject_cnt_next = '0;
               end else begin
                  reject_cnt_next = reject_inc;
                  if (limit_hit) begin
                     no_target_next  = 1'b1;
                     filt_valid_next = 1'b1;
                     filt_next       = '0;
                     state_next      = ST_EMPTY;
                  end
               end
            end
            default: state_next = ST_EMPTY;
         endcase
      end
   end

   assign filt_cycles = filt_reg;
   assign filt_valid  = filt_valid_reg;
   assign no_target   = no_target_reg;
   assign reject_cnt  = reject_cnt_reg;

endmodule

// File: tb/tb_echo_filter.sv
// Scoreboard bench for echo_filter: stimulus pushes expected outputs, a monitor
// pops and compares on every filt_valid.
module tb_echo_filter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [31:0] sample_cycles = '0;
   logic [31:0] filt_cycles;
   logic        filt_valid;
   logic        no_target;
   logic [7:0]  reject_cnt;

   always #5 clk = ~clk;

   echo_filter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_cycles(sample_cycles),
      .filt_cycles  (filt_cycles),
      .filt_valid   (filt_valid),
      .no_target    (no_target),
      .reject_cnt   (reject_cnt)
   );

   typedef struct {
      int          cyc;
      logic [31:0] filt;
      logic        nt;
      logic [7:0]  rc;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, req, cyc);
      end
   endtask

   // Monitor: one line per output transaction
   always @(negedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      if (filt_valid === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got filt_cycles=%0d at cycle %0d, required no output",
                     filt_cycles, cyc);
         end else begin
            e = sb.pop_front();
            $display("[TB] out cyc=%0d filt=%0d no_target=%0b reject_cnt=%0d", cyc,
                     filt_cycles, no_target, reject_cnt);
            cmp("out_latency", 32'(cyc), 32'(e.cyc));
            cmp("out_filt", filt_cycles, e.filt);
            cmp("out_no_target", {31'd0, no_target}, {31'd0, e.nt});
            cmp("out_reject_cnt", {24'd0, reject_cnt}, {24'd0, e.rc});
         end
      end
   end

   task automatic strobe(input logic [31:0] x, input bit expv, input logic [31:0] ef,
                         input logic ent, input logic [7:0] erc);
      exp_t e;
      @(posedge clk);
      #1;
      sample_valid  = 1'b1;
      sample_cycles = x;
      if (expv) begin
         e.cyc  = cyc + 3;
         e.filt = ef;
         e.nt   = ent;
         e.rc   = erc;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      repeat (n - 1) @(posedge clk);
   endtask

   task automatic check_state(input string name, input logic [31:0] ef, input logic ent,
                              input logic [7:0] erc);
      @(negedge clk);
      #1;
      $display("[TB] chk %s filt=%0d no_target=%0b reject_cnt=%0d valid=%0b", name,
               filt_cycles, no_target, reject_cnt, filt_valid);
      cmp({name, "_filt"}, filt_cycles, ef);
      cmp({name, "_no_target"}, {31'd0, no_target}, {31'd0, ent});
      cmp({name, "_reject_cnt"}, {24'd0, reject_cnt}, {24'd0, erc});
      cmp({name, "_valid"}, {31'd0, filt_valid}, 32'd0);
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      rst_n = 1'b0;
      check_state("reset", 32'd0, 1'b1, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int wait_cyc;
      // Reset state
      check_state("por", 32'd0, 1'b1, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      check_state("idle_after_reset", 32'd0, 1'b1, 8'd0);

      // First sample primes the filter
      strobe(32'd5000, 1, 32'd5000, 1'b0, 8'd0);
      idle(3);

      // Averaging over the 4-deep window
      reset_pulse();
      strobe(32'd4000, 1, 32'd4000, 1'b0, 8'd0);
      strobe(32'd8000, 1, 32'd5000, 1'b0, 8'd0);
      strobe(32'd8000, 1, 32'd6000, 1'b0, 8'd0);
      strobe(32'd8000, 1, 32'd7000, 1'b0, 8'd0);
      strobe(32'd8000, 1, 32'd8000, 1'b0, 8'd0);
      idle(3);
      check_state("avg_hold", 32'd8000, 1'b0, 8'd0);

      // Loss of target after four rejects, then re-acquire
      strobe(32'd0, 0, 32'd0, 1'b0, 8'd0);
      strobe(32'd0, 0, 32'd0, 1'b0, 8'd0);
      strobe(32'd0, 0, 32'd0, 1'b0, 8'd0);
      idle(3);
      check_state("three_rejects", 32'd8000, 1'b0, 8'd3);
      strobe(32'd0, 1, 32'd0, 1'b1, 8'd4);
      idle(3);
      check_state("lost", 32'd0, 1'b1, 8'd4);
      strobe(32'd6000, 1, 32'd6000, 1'b0, 8'd0);
      idle(3);

      // Range boundaries
      reset_pulse();
      strobe(32'd5000, 1, 32'd5000, 1'b0, 8'd0);
      strobe(32'd1399, 0, 32'd0, 1'b0, 8'd0);
      strobe(32'd280001, 0, 32'd0, 1'b0, 8'd0);
      idle(3);
      check_state("out_of_range", 32'd5000, 1'b0, 8'd2);
      strobe(32'd1400, 1, 32'd4100, 1'b0, 8'd0);
      strobe(32'd280000, 1, 32'd72850, 1'b0, 8'd0);
      idle(3);

      // Extreme rejects, then a sample right behind the reject-to-EMPTY transition
      strobe(32'hFFFF_FFFF, 0, 32'd0, 1'b0, 8'd0);
      strobe(32'd0, 0, 32'd0, 1'b0, 8'd0);
      strobe(32'd0, 0, 32'd0, 1'b0, 8'd0);
      strobe(32'd0, 1, 32'd0, 1'b1, 8'd4);
      strobe(32'd3000, 1, 32'd3000, 1'b0, 8'd0);
      strobe(32'd3100, 1, 32'd3025, 1'b0, 8'd0);
      idle(3);

      // Reject counter saturation
      for (int i = 0; i < 260; i++)
         strobe(32'd0, (i == 3), 32'd0, 1'b1, 8'd4);
      idle(3);
      check_state("saturate", 32'd0, 1'b1, 8'd255);

      // Reset with samples in flight
      strobe(32'd8800, 1, 32'd8800, 1'b0, 8'd0);
      idle(3);
      strobe(32'd9100, 0, 32'd0, 1'b0, 8'd0);
      strobe(32'd9200, 0, 32'd0, 1'b0, 8'd0);
      #3;
      rst_n = 1'b0;
      sample_valid = 1'b0;
      check_state("mid_reset", 32'd0, 1'b1, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(5);
      check_state("after_mid_reset", 32'd0, 1'b1, 8'd0);
      strobe(32'd9000, 1, 32'd9000, 1'b0, 8'd0);
      strobe(32'd9400, 1, 32'd9100, 1'b0, 8'd0);
      idle(3);

      // Drain scoreboard with a bounded wait
      wait_cyc = 0;
      while (sb.size() != 0 && wait_cyc < 20) begin
         @(posedge clk);
         wait_cyc++;
      end
      cmp("drain_pending", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
